trig_event_fifo: RTL

TRIG_EVENT_FIFO -- requirements
Module: trig_event_fifo

---
 rtl/trig_event_fifo.sv | 77 +++++++
 1 files changed

// File: rtl/trig_event_fifo.sv
// trig_event_fifo: captures {trig_number, timestamp} on trig_in rising edges into a FIFO
// and streams each entry out as two 32-bit words (high word first) over a valid/ready port.
module trig_event_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_adc,
    input  logic                  rst,
    input  logic                  trig_in,
    input  logic [7:0]            trig_number,
    input  logic [55:0]           clock_counter,
    input  logic                  clear_flags,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic [15:0]           drop_count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t                  state;
    logic [63:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [31:0]             held_lo;
    logic                    trig_in_d, capture, full, push, drop, pop;
    logic [63:0]             head;

    assign capture = trig_in & ~trig_in_d;
    // Fullness uses the registered count only, so a same-cycle pop never frees a slot.
    assign full    = fifo_count == (DEPTH_LOG2 + 1)'(DEPTH);
    assign push    = capture & ~full;
    assign drop    = capture & full;
    assign pop     = (fifo_count != 0) && (state == IDLE || (state == LO && out_ready));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_adc) begin
        if (push) mem[wr_ptr] <= {trig_number, clock_counter};
    end

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            trig_in_d  <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            held_lo    <= '0;
        end else begin
            trig_in_d  <= trig_in;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
            overflow   <= drop | (overflow & ~clear_flags);
            drop_count <= clear_flags ? {15'd0, drop} :
                          (drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
            // A pop from IDLE or from LO-with-handshake both load the next entry straight into HI.
            if (pop) begin
                state     <= HI;
                out_valid <= 1'b1;
                out_data  <= head[63:32];
                held_lo   <= head[31:0];
            end else if (state == HI && out_ready) begin
                state    <= LO;
                out_data <= held_lo;
            end else if (state == LO && out_ready) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end
endmodule
